// File: rtl/ro_freq_counter_pkg.sv
// Shared constants for the ring-oscillator frequency counter: FSM state
// encoding, default build parameters and the result saturation value.
package ro_freq_counter_pkg;

  // Default build parameters (1 ms window at 100 MHz, 16-bit edge counter).
  localparam int unsigned DEF_GATE_CYCLES = 100000;
  localparam int unsigned DEF_SHIFT       = 0;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Value reported when the scaled edge count does not fit in one byte.
  localparam logic [7:0] SAT_BYTE = 8'hFF;

  // Measurement FSM encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer chain for an asynchronous input followed by a single-cycle
// rising-edge pulse generator on the synchronized level.
module sync_edge_det
  import ro_freq_counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic [SYNC_STAGES:0]   chain_next;

  // Next value of the chain: every stage takes its neighbour, stage 0 the pin.
  always_comb begin
    chain_next = {sync_q, async_in};
  end

  // Shift the input through the chain and remember the last stage's old value.
  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= chain_next[SYNC_STAGES-1:0];
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising edge: synchronized level is high now and was low one cycle ago.
  always_comb begin
    rise = sync_q[SYNC_STAGES-1] & ~last_q;
  end

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts rising edges of ro_in over
// back-to-back gate windows of GATE_CYCLES clocks and hands one scaled,
// saturated result byte per window to a ready/valid byte consumer.
module ro_freq_counter
  import ro_freq_counter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned SHIFT       = DEF_SHIFT,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ro_in,
  input  logic       preset_en,
  input  logic [7:0] preset_val,
  input  logic       tx_ready,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       overrun
);

  localparam int unsigned        GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  logic [0:0]        state_q;
  logic [GATE_W-1:0] gate_q;
  logic [CNT_W-1:0]  edge_cnt_q;

  logic              ro_rise;
  logic              terminal;
  logic              transfer;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W+7:0]  cnt_shifted;
  logic [7:0]        result;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk      (clk),
    .rst      (rst),
    .async_in (ro_in),
    .rise     (ro_rise)
  );

  // Window bookkeeping and result formatting: saturating edge count including
  // the current cycle's edge, then scale and clamp to one byte.
  // NOTE: every always_comb output gets a value on every path (defaults up
  // front) so no latch can be inferred.
  always_comb begin
    terminal    = 1'b0;
    cnt_next    = edge_cnt_q;
    cnt_shifted = '0;
    result      = 8'h00;

    terminal = (state_q == ST_COUNT) && en && (gate_q == GATE_LAST);
    if (ro_rise && (edge_cnt_q != CNT_MAX)) begin
      cnt_next = edge_cnt_q + 1'b1;
    end
    cnt_shifted = {8'h00, cnt_next} >> SHIFT;
    if (preset_en) begin
      result = preset_val;
    end else if (|cnt_shifted[CNT_W+7:8]) begin
      result = SAT_BYTE;
    end else begin
      result = cnt_shifted[7:0];
    end
    transfer = data_valid && tx_ready;
  end

  // Measurement FSM with gate and edge counters; windows run back to back and
  // dropping en discards the partial window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gate_q     <= '0;
      edge_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          gate_q     <= '0;
          edge_cnt_q <= '0;
          if (en) begin
            state_q <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!en) begin
            state_q    <= ST_IDLE;
            gate_q     <= '0;
            edge_cnt_q <= '0;
          end else if (gate_q == GATE_LAST) begin
            gate_q     <= '0;
            edge_cnt_q <= '0;
          end else begin
            gate_q     <= gate_q + 1'b1;
            edge_cnt_q <= cnt_next;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          gate_q     <= '0;
          edge_cnt_q <= '0;
        end
      endcase
    end
  end

  // Output holding register: load a finished result when the slot is free or
  // being emptied this cycle, otherwise drop it and flag the loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= 8'h00;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (terminal) begin
        if (!data_valid || transfer) begin
          data       <= result;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (transfer) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter. Three instances share all inputs:
// u0 (1000-cycle window, no shift), u1 (2000, no shift), u2 (2000, shift 2).
// ro_in is a periodic square wave whose period divides the window length, so
// every window holds exactly window/period rising edges regardless of phase.
module tb_ro_freq_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ro_in = 1'b0;
  logic       preset_en = 1'b0;
  logic [7:0] preset_val = 8'h00;
  logic       tx_ready = 1'b1;

  logic [7:0] data_a [3];
  logic       dv_a   [3];
  logic       ovr_a  [3];

  int errors = 0;
  int checks = 0;

  int ro_period = 4;
  int ro_high   = 2;
  int ro_phase  = 0;

  ro_freq_counter #(.GATE_CYCLES(1000), .SHIFT(0), .CNT_W(16), .SYNC_STAGES(2)) u0 (
    .clk(clk), .rst(rst), .en(en), .ro_in(ro_in), .preset_en(preset_en),
    .preset_val(preset_val), .tx_ready(tx_ready),
    .data(data_a[0]), .data_valid(dv_a[0]), .overrun(ovr_a[0]));

  ro_freq_counter #(.GATE_CYCLES(2000), .SHIFT(0), .CNT_W(16), .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .ro_in(ro_in), .preset_en(preset_en),
    .preset_val(preset_val), .tx_ready(tx_ready),
    .data(data_a[1]), .data_valid(dv_a[1]), .overrun(ovr_a[1]));

  ro_freq_counter #(.GATE_CYCLES(2000), .SHIFT(2), .CNT_W(16), .SYNC_STAGES(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .ro_in(ro_in), .preset_en(preset_en),
    .preset_val(preset_val), .tx_ready(tx_ready),
    .data(data_a[2]), .data_valid(dv_a[2]), .overrun(ovr_a[2]));

  always #5 clk = ~clk;

  // Oscillator model: changes only on falling clk edges, high for ro_high of
  // every ro_period cycles.
  always @(negedge clk) begin
    ro_phase = (ro_phase + 1) % ro_period;
    ro_in    = (ro_phase < ro_high);
  end

  // Reference: edges per window from the oscillator period, scaled, clamped.
  function automatic logic [7:0] model_byte(input int gate, input int period, input int shift);
    int n;
    n = (gate / period) >> shift;
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  task automatic do_reset();
    en = 1'b0; preset_en = 1'b0; preset_val = 8'h00; tx_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_ro(input int period, input int high);
    ro_period = period;
    ro_high   = high;
  endtask

  // Wait (bounded) for data_valid on instance idx; cycles = falling edges seen.
  task automatic wait_dv(input int idx, input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (dv_a[idx] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({data_a[i], dv_a[i], ovr_a[i]} !== 10'h000) begin
        errors++;
        $display("FAIL reset_outputs u%0d: got data=%h dv=%b ovr=%b expected 00/0/0",
                 i, data_a[i], dv_a[i], ovr_a[i]);
      end
    end
    rst = 1'b0;
    seen = 0;
    repeat (1200) begin
      @(negedge clk);
      if (dv_a[0] === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL idle_no_result: got %0d valid cycles expected 0", seen);
    end
  endtask

  task automatic test_basic();
    int c; bit ok;
    do_reset();
    set_ro(4, 2);
    en = 1'b1;
    wait_dv(0, 1200, c, ok);
    checks++;
    if (!ok || c !== 1001) begin
      errors++;
      $display("FAIL basic_first_latency: got %0d (ok=%0b) expected 1001", c, ok);
    end
    checks++;
    if (data_a[0] !== 8'hFA) begin
      errors++;
      $display("FAIL basic_first_data: got %h expected fa", data_a[0]);
    end
    for (int w = 0; w < 3; w++) begin
      wait_dv(0, 1200, c, ok);
      checks++;
      if (!ok || c !== 1000) begin
        errors++;
        $display("FAIL basic_spacing w%0d: got %0d (ok=%0b) expected 1000", w, c, ok);
      end
      checks++;
      if (data_a[0] !== 8'hFA || ovr_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL basic_data w%0d: got %h ovr=%b expected fa ovr=0", w, data_a[0], ovr_a[0]);
      end
    end
  endtask

  task automatic test_saturation();
    int c; bit ok;
    do_reset();
    set_ro(4, 2);
    en = 1'b1;
    wait_dv(1, 2200, c, ok);
    checks++;
    if (!ok || c !== 2001) begin
      errors++;
      $display("FAIL sat_latency: got %0d (ok=%0b) expected 2001", c, ok);
    end
    checks++;
    if (data_a[1] !== 8'hFF) begin
      errors++;
      $display("FAIL sat_clamp: got %h expected ff", data_a[1]);
    end
    checks++;
    if (dv_a[2] !== 1'b1 || data_a[2] !== 8'h7D) begin
      errors++;
      $display("FAIL sat_shift2: got %h dv=%b expected 7d dv=1", data_a[2], dv_a[2]);
    end
  endtask

  task automatic test_random();
    int divs [12] = '{4, 5, 8, 10, 20, 25, 40, 50, 100, 125, 200, 250};
    int c; bit ok; int p; int h;
    logic [7:0] e0, e1, e2;
    do_reset();
    en = 1'b1;
    for (int it = 0; it < 5; it++) begin
      p = divs[$urandom_range(0, 11)];
      h = $urandom_range(2, p - 2);
      set_ro(p, h);
      e0 = model_byte(1000, p, 0);
      e1 = model_byte(2000, p, 0);
      e2 = model_byte(2000, p, 2);
      wait_dv(1, 2200, c, ok);   // window straddling the change: not checked
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_settle_timeout it%0d: got no result expected one", it);
      end
      wait_dv(0, 1100, c, ok);
      checks++;
      if (!ok || data_a[0] !== e0) begin
        errors++;
        $display("FAIL rand_u0 it%0d p=%0d: got %h (ok=%0b) expected %h", it, p, data_a[0], ok, e0);
      end
      wait_dv(1, 1100, c, ok);
      checks++;
      if (!ok || data_a[1] !== e1) begin
        errors++;
        $display("FAIL rand_u1 it%0d p=%0d: got %h (ok=%0b) expected %h", it, p, data_a[1], ok, e1);
      end
      checks++;
      if (dv_a[2] !== 1'b1 || data_a[2] !== e2) begin
        errors++;
        $display("FAIL rand_u2 it%0d p=%0d: got %h dv=%b expected %h", it, p, data_a[2], dv_a[2], e2);
      end
      checks++;
      if (dv_a[0] !== 1'b1 || data_a[0] !== e0) begin
        errors++;
        $display("FAIL rand_u0_aligned it%0d p=%0d: got %h dv=%b expected %h", it, p, data_a[0], dv_a[0], e0);
      end
    end
  endtask

  task automatic test_preset();
    int c; bit ok;
    do_reset();
    set_ro(4, 2);
    en = 1'b1;
    wait_dv(0, 1200, c, ok);
    preset_en = 1'b1;
    preset_val = 8'hA5;
    set_ro(8, 3);
    for (int w = 0; w < 2; w++) begin
      wait_dv(0, 1100, c, ok);
      checks++;
      if (!ok || data_a[0] !== 8'hA5) begin
        errors++;
        $display("FAIL preset_value w%0d: got %h (ok=%0b) expected a5", w, data_a[0], ok);
      end
    end
    preset_en = 1'b0;
    wait_dv(0, 1100, c, ok);
    checks++;
    if (!ok || data_a[0] !== model_byte(1000, 8, 0)) begin
      errors++;
      $display("FAIL preset_release: got %h (ok=%0b) expected %h", data_a[0], ok, model_byte(1000, 8, 0));
    end
  endtask

  task automatic test_back_to_back();
    int c; bit ok; bit stable;
    do_reset();
    set_ro(4, 2);
    en = 1'b1;
    wait_dv(0, 1200, c, ok);
    tx_ready = 1'b0;
    preset_en = 1'b1;
    preset_val = 8'h11;
    stable = 1'b1;
    for (int k = 1; k < 1000; k++) begin
      @(negedge clk);
      if (dv_a[0] !== 1'b1 || data_a[0] !== 8'hFA) stable = 1'b0;
    end
    checks++;
    if (!ok || !stable) begin
      errors++;
      $display("FAIL hold_stable: got stable=%0b ok=%0b expected 1/1", stable, ok);
    end
    // Transfer on the same edge a new result arrives: new byte loads, no loss.
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (data_a[0] !== 8'h11 || dv_a[0] !== 1'b1 || ovr_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL xfer_and_load: got %h dv=%b ovr=%b expected 11/1/0", data_a[0], dv_a[0], ovr_a[0]);
    end
    tx_ready = 1'b0;
    preset_val = 8'h3C;
    stable = 1'b1;
    for (int k = 1; k < 1000; k++) begin
      @(negedge clk);
      if (dv_a[0] !== 1'b1 || data_a[0] !== 8'h11) stable = 1'b0;
    end
    checks++;
    if (!stable || ovr_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL pre_overrun: got stable=%0b ovr=%b expected 1/0", stable, ovr_a[0]);
    end
    @(negedge clk);
    checks++;
    if (data_a[0] !== 8'h11 || dv_a[0] !== 1'b1 || ovr_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL overrun_drop: got %h dv=%b ovr=%b expected 11/1/1", data_a[0], dv_a[0], ovr_a[0]);
    end
    repeat (10) @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (dv_a[0] !== 1'b0 || ovr_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL drain: got dv=%b ovr=%b expected 0/1", dv_a[0], ovr_a[0]);
    end
    preset_en = 1'b0;
  endtask

  task automatic test_disruption();
    int c; bit ok; int seen;
    do_reset();
    set_ro(4, 2);
    en = 1'b1;
    repeat (500) @(negedge clk);
    en = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (dv_a[0] === 1'b1) seen++;
    end
    en = 1'b1;
    wait_dv(0, 1200, c, ok);
    checks++;
    if (!ok || c !== 1001 || seen !== 0) begin
      errors++;
      $display("FAIL en_restart: got %0d cycles (ok=%0b, early=%0d) expected 1001", c, ok, seen);
    end
    checks++;
    if (data_a[0] !== 8'hFA) begin
      errors++;
      $display("FAIL en_restart_data: got %h expected fa", data_a[0]);
    end
    tx_ready = 1'b0;
    repeat (300) @(negedge clk);
    checks++;
    if (dv_a[0] !== 1'b1 || data_a[0] !== 8'hFA) begin
      errors++;
      $display("FAIL pending_before_rst: got %h dv=%b expected fa/1", data_a[0], dv_a[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (data_a[0] !== 8'h00 || dv_a[0] !== 1'b0 || ovr_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: got %h dv=%b ovr=%b expected 00/0/0", data_a[0], dv_a[0], ovr_a[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    tx_ready = 1'b1;
    wait_dv(0, 1200, c, ok);
    checks++;
    if (!ok || c !== 1001 || data_a[0] !== 8'hFA) begin
      errors++;
      $display("FAIL post_rst_window: got %0d cycles data=%h (ok=%0b) expected 1001/fa", c, data_a[0], ok);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_random();
    test_preset();
    test_back_to_back();
    test_disruption();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ro_freq_counter.md
RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

Interface
REQ-001 Parameter GATE_CYCLES, default 100000: length of one measurement window in clk cycles (1 ms at 100 MHz).
REQ-002 Parameter SHIFT, default 0: right-shift applied to the raw edge count before 8-bit saturation.
REQ-003 Parameter CNT_W, default 16: edge-counter width.
REQ-004 Parameter SYNC_STAGES, default 2: synchronizer depth on ro_in.
REQ-005 Ports, in order:
  clk  in  1  system clock, single clock domain;
  rst  in  1  asynchronous, active-high reset;
  en  in  1  measurement enable;
  ro_in  in  1  ring-oscillator output (prescaled), asynchronous to clk;
  preset_en  in  1  substitute preset_val for the measured result;
  preset_val  in  8  substitute value;
  tx_ready  in  1  downstream UART transmitter can accept a byte;
  data  out  8  result byte;
  data_valid  out  1  data holds an unconsumed result;
  overrun  out  1  sticky flag: a result was dropped.

Function
REQ-006 ro_in shall pass through a SYNC_STAGES flop chain; a rising edge is detected when the last stage is 1 and its previous-cycle value is 0; detection latency is at most SYNC_STAGES+1 cycles.
REQ-007 ro_in frequency below clk/4 shall be counted exactly; higher rates are out of specification.
REQ-008 FSM states: IDLE and COUNT; IDLE->COUNT on the cycle en=1 is sampled; COUNT->IDLE on the cycle en=0 is sampled.
REQ-009 In COUNT, a gate counter shall run 0..GATE_CYCLES-1; edge_cnt increments on each detected edge and saturates at 2^CNT_W-1.
REQ-010 On the terminal gate cycle, the result includes any edge detected in that same cycle; gate counter and edge_cnt restart at 0 the next cycle; windows run back to back with no dead cycles.
REQ-011 Result = min(edge_cnt >> SHIFT, 255); if preset_en=1 on the terminal cycle, result = preset_val instead.
REQ-012 Result is presented on the cycle after the terminal cycle: data=result, data_valid=1.
REQ-013 Handshake: transfer occurs on a cycle with data_valid=1 and tx_ready=1; data_valid falls the next cycle unless a new result loads that cycle; data shall not change while data_valid=1 and no transfer occurs.
REQ-014 Result arriving while data_valid=1 and tx_ready=0: the new result is dropped, data is retained, and overrun is set to 1.
REQ-015 Result arriving in the same cycle as a transfer: the new result loads and data_valid stays 1; no overrun.
REQ-016 en deassert mid-window: the partial window is discarded and the gate counter and edge_cnt clear; a pending data/data_valid is kept until transferred.
REQ-017 overrun clears only on rst.

Reset
REQ-018 rst asynchronous: state=IDLE; gate counter, edge_cnt and synchronizer flops = 0; data=8'h00; data_valid=0; overrun=0.
REQ-019 rst asserted mid-window or with data pending shall discard all state; the first result after release requires a full GATE_CYCLES window from entry into COUNT.

Structure
REQ-020 Shared package: FSM state encoding, default GATE_CYCLES/SHIFT/CNT_W constants, and the 8'hFF saturation constant.
REQ-021 One sub-module, sync_edge_det (synchronizer plus rising-edge detector, parameter SYNC_STAGES); the rest stays flat.

Verification (GATE_CYCLES=1000, clk 100 MHz)
REQ-022 Basic count: en=1, ro_in period 40 ns, tx_ready=1, SHIFT=0 -> each window yields data=8'hFA (250 edges); results spaced 1000 cycles apart.
REQ-023 Saturation: ro_in period 40 ns, GATE_CYCLES=2000 -> data=8'hFF; with SHIFT=2 -> data=8'h7D.
REQ-024 Preset: preset_en=1, preset_val=8'hA5 -> each result=8'hA5 regardless of ro_in; after preset_en=0, the next full window returns to the measured value.
REQ-025 Backpressure: tx_ready=0 across two window ends -> first byte held stable with data_valid=1 and overrun=1; tx_ready=1 -> one transfer, then data_valid=0.
REQ-026 Disruption: en=0 at gate count 500, en=1 again -> no result until 1000 cycles later; rst pulse mid-window -> all outputs return to reset values immediately.
